// File: rtl/csi2_delay_calib_if.sv
// Receiver-side bundle for the CSI2 DPHY input-delay calibrator.
// The master drives the start pulse and the header status; the slave drives the delay controls.
interface csi2_delay_calib_if #(
  parameter int DATA_LANES = 2,
  parameter int TAP_W      = 5
);
  logic                        start_i;
  logic                        header_valid_i;
  logic                        header_err_i;
  logic                        crc_err_i;
  logic                        enable_o;
  logic                        delay_act_o;
  logic [DATA_LANES*TAP_W-1:0] lane_delay_o;
  logic                        busy_o;
  logic                        done_o;
  logic                        fail_o;

  modport master (
    output start_i, header_valid_i, header_err_i, crc_err_i,
    input  enable_o, delay_act_o, lane_delay_o, busy_o, done_o, fail_o
  );

  modport slave (
    input  start_i, header_valid_i, header_err_i, crc_err_i,
    output enable_o, delay_act_o, lane_delay_o, busy_o, done_o, fail_o
  );
endinterface

// File: rtl/csi2_delay_calib.sv
// Sweeps each lane's IDELAY tap, scores every tap on received header/CRC health,
// and loads the centre of the widest clean tap window per lane.
module csi2_delay_calib #(
  parameter int DATA_LANES     = 2,
  parameter int TAP_W          = 5,
  parameter int DEFAULT_TAP    = 15,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int HDR_WINDOW     = 64,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input logic               clk_i,
  input logic               rstn_i,
  csi2_delay_calib_if.slave bus
);

  localparam int LANE_W = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
  localparam int HDR_W  = $clog2(HDR_WINDOW + 1);
  localparam int TIM_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LEN_W  = TAP_W + 1;

  localparam logic [TAP_W-1:0]  TAP_MAX   = '1;
  localparam logic [TAP_W-1:0]  TAP_DEF   = TAP_W'(DEFAULT_TAP);
  localparam logic [HDR_W-1:0]  HDR_FULL  = HDR_W'(HDR_WINDOW);
  localparam logic [TIM_W-1:0]  TIM_LAST  = TIM_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(DATA_LANES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_APPLY, S_ACT, S_SETTLE, S_MEASURE, S_EVAL, S_CENTER, S_CENTER_ACT, S_DONE
  } state_e;

  state_e                             state_q;
  logic [LANE_W-1:0]                  lane_q;
  logic [TAP_W-1:0]                   tap_q;
  logic [DATA_LANES-1:0][TAP_W-1:0]   lane_delay_q;
  logic                               enable_q, delay_act_q, busy_q, done_q, fail_q;
  logic [SET_W-1:0]                   settle_q;
  logic [TIM_W-1:0]                   timer_q;
  logic [HDR_W-1:0]                   hdr_cnt_q, hdr_cnt_d;
  logic                               err_flag_q, err_flag_d;
  logic [LEN_W-1:0]                   run_len_q, run_len_d, best_len_q, best_len_d;
  logic [TAP_W-1:0]                   run_start_q, run_start_d, best_start_q, best_start_d;
  logic [TAP_W-1:0]                   center_tap;
  logic                               tap_pass;

  assign bus.enable_o     = enable_q;
  assign bus.delay_act_o  = delay_act_q;
  assign bus.lane_delay_o = lane_delay_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.fail_o       = fail_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hdr_cnt_d  = hdr_cnt_q;
    err_flag_d = err_flag_q;
    if (bus.header_valid_i && (hdr_cnt_q != HDR_FULL)) hdr_cnt_d = hdr_cnt_q + 1'b1;
    if ((bus.header_valid_i && bus.header_err_i) || bus.crc_err_i) err_flag_d = 1'b1;

    tap_pass    = (hdr_cnt_q == HDR_FULL) && !err_flag_q;
    run_len_d   = tap_pass ? run_len_q + 1'b1 : '0;
    run_start_d = (tap_pass && (run_len_q == '0)) ? tap_q : run_start_q;

    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    if (run_len_d > best_len_q) begin
      best_len_d   = run_len_d;
      best_start_d = run_start_d;
    end
    center_tap = TAP_W'({1'b0, best_start_d} + (best_len_d >> 1));
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      // NOTE: the tap array is a handful of flops feeding the IDELAYs, so it is reset like any control register.
      state_q      <= S_IDLE;
      lane_q       <= '0;
      tap_q        <= '0;
      lane_delay_q <= {DATA_LANES{TAP_DEF}};
      enable_q     <= 1'b0;
      delay_act_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      settle_q     <= '0;
      timer_q      <= '0;
      hdr_cnt_q    <= '0;
      err_flag_q   <= 1'b0;
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else begin
      delay_act_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start_i) begin
          for (int k = 0; k < DATA_LANES; k++) lane_delay_q[k] <= TAP_DEF;
          lane_delay_q[0] <= '0;
          lane_q   <= '0;
          tap_q    <= '0;
          enable_q <= 1'b0;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
          fail_q   <= 1'b0;
          state_q  <= S_APPLY;
        end
        S_APPLY: begin
          delay_act_q <= 1'b1;
          state_q     <= S_ACT;
        end
        S_ACT: begin
          settle_q <= '0;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          settle_q <= settle_q + 1'b1;
          if (settle_q == SET_LAST) begin
            enable_q   <= 1'b1;
            hdr_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          hdr_cnt_q  <= hdr_cnt_d;
          err_flag_q <= err_flag_d;
          timer_q    <= timer_q + 1'b1;
          if ((hdr_cnt_d == HDR_FULL) || (timer_q == TIM_LAST)) state_q <= S_EVAL;
        end
        S_EVAL: begin
          run_len_q    <= run_len_d;
          run_start_q  <= run_start_d;
          best_len_q   <= best_len_d;
          best_start_q <= best_start_d;
          if (tap_q != TAP_MAX) begin
            tap_q                <= tap_q + 1'b1;
            lane_delay_q[lane_q] <= tap_q + 1'b1;
            enable_q             <= 1'b0;
            state_q              <= S_APPLY;
          end else begin
            // Field is loaded here so delay_act follows it by exactly one cycle.
            lane_delay_q[lane_q] <= (best_len_d == '0) ? TAP_DEF : center_tap;
            if (best_len_d == '0) fail_q <= 1'b1;
            state_q <= S_CENTER;
          end
        end
        S_CENTER: begin
          delay_act_q <= 1'b1;
          state_q     <= S_CENTER_ACT;
        end
        S_CENTER_ACT: begin
          run_len_q    <= '0;
          run_start_q  <= '0;
          best_len_q   <= '0;
          best_start_q <= '0;
          if (lane_q != LANE_LAST) begin
            lane_q                      <= lane_q + 1'b1;
            tap_q                       <= '0;
            lane_delay_q[lane_q + 1'b1] <= '0;
            enable_q                    <= 1'b0;
            state_q                     <= S_APPLY;
          end else begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            enable_q <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
